// File: rtl/pcie_class_arbiter_if.sv
// Handshake bundle between the class arbiter, its NUM_IN input FIFOs and its
// NUM_OUT per-class output FIFOs.
interface pcie_class_arbiter_if #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 10
);
    logic [NUM_IN-1:0]        in_empty;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_OUT-1:0]       out_almost_full;
    logic [NUM_IN-1:0]        pop;
    logic [NUM_OUT-1:0]       push;
    logic [DATA_W-1:0]        data_out;
    logic                     class_err;
    logic                     idle;

    // FIFO side: owns the flags and read data, consumes the strobes.
    modport master (
        output in_empty, in_data, out_almost_full,
        input  pop, push, data_out, class_err, idle
    );

    // Arbiter side.
    modport slave (
        input  in_empty, in_data, out_almost_full,
        output pop, push, data_out, class_err, idle
    );
endinterface

// File: rtl/pcie_class_arbiter.sv
// Class-routing arbiter: pops one non-empty input per cycle and pushes the word
// into the output FIFO selected by its class field. `ARB_ROUND_ROBIN_EN picks RR over fixed priority.
module pcie_class_arbiter #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    pcie_class_arbiter_if.slave  bus
);
    localparam int CLASS_W = $clog2(NUM_OUT);
    localparam int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic                r_s1_valid;
    logic [SEL_W-1:0]    r_s1_sel;
    logic                r_s2_valid;
    logic [NUM_OUT-1:0]  r_push;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_class_err;

    logic                w_req;
    logic                w_gnt_vld;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic [NUM_IN-1:0]   w_pop;
    logic [DATA_W-1:0]   w_s1_word;
    logic [CLASS_W-1:0]  w_cls;

    // Backpressure is global: any almost-full output stalls every input.
    assign w_req = !reset && !(|bus.out_almost_full) && !(&bus.in_empty);

`ifdef ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] r_last_grant;
    int               w_j;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_j       = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_j = (int'(r_last_grant) + 1 + k) % NUM_IN;
            if (w_req && !w_gnt_vld && !bus.in_empty[w_j]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = SEL_W'(w_j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_last_grant <= SEL_W'(NUM_IN - 1);
        else if (w_gnt_vld)
            r_last_grant <= w_gnt_idx;
    end
`else
    // Descending scan so the lowest-index non-empty input is the last writer.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (w_req && !bus.in_empty[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = SEL_W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_pop = '0;
        if (w_gnt_vld)
            w_pop[w_gnt_idx] = 1'b1;
    end

    assign w_s1_word = bus.in_data[r_s1_sel*DATA_W +: DATA_W];
    assign w_cls     = w_s1_word[DATA_W-1 -: CLASS_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_sel    <= '0;
            r_s2_valid  <= 1'b0;
            r_push      <= '0;
            r_data_out  <= '0;
            r_class_err <= 1'b0;
        end else begin
            r_s1_valid <= w_gnt_vld;
            if (w_gnt_vld)
                r_s1_sel <= w_gnt_idx;
            r_s2_valid  <= r_s1_valid;
            r_push      <= '0;
            r_class_err <= 1'b0;
            if (r_s1_valid) begin
                r_data_out <= w_s1_word;
                // Classes past NUM_OUT have no FIFO: drop and flag.
                if (int'(w_cls) < NUM_OUT)
                    r_push <= NUM_OUT'(1) << w_cls;
                else
                    r_class_err <= 1'b1;
            end
        end
    end

    assign bus.pop       = w_pop;
    assign bus.push      = r_push;
    assign bus.data_out  = r_data_out;
    assign bus.class_err = r_class_err;
    assign bus.idle      = !r_s1_valid && !r_s2_valid;
endmodule

// File: tb/tb_pcie_class_arbiter.sv
// Directed bench for pcie_class_arbiter: a 4-class instance for grant/route/stall
// behaviour and a 3-class instance for out-of-range class drops.
module tb_pcie_class_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pcie_class_arbiter_if #(.NUM_IN(4), .NUM_OUT(4), .DATA_W(10)) bus_a ();
    pcie_class_arbiter_if #(.NUM_IN(4), .NUM_OUT(3), .DATA_W(10)) bus_b ();

    pcie_class_arbiter #(.NUM_IN(4), .NUM_OUT(4), .DATA_W(10)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    pcie_class_arbiter #(.NUM_IN(4), .NUM_OUT(3), .DATA_W(10)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input i carries class i and a recognisable payload.
    function automatic logic [9:0] word(input int i);
        return 10'((i << 8) | (16 + i));
    endfunction

    // Input granted on the k-th consecutive cycle with all inputs non-empty.
    function automatic int exp_idx(input int k);
`ifdef ARB_ROUND_ROBIN_EN
        return k % 4;
`else
        return 0;
`endif
    endfunction

    initial begin
        reset = 1'b1;
        bus_a.in_empty = 4'b0000;
        bus_a.out_almost_full = 4'b0000;
        for (int i = 0; i < 4; i++) bus_a.in_data[i*10 +: 10] = word(i);
        bus_b.in_empty = 4'b1111;
        bus_b.out_almost_full = 3'b000;
        bus_b.in_data = '0;

        // Reset held three cycles with every input non-empty.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_pop", bus_a.pop, 4'b0000);
            chk("rst_push", bus_a.push, 4'b0000);
            chk("rst_idle", bus_a.idle, 1'b1);
        end
        chk("rst_data", bus_a.data_out, 10'h000);
        chk("rst_cerr", bus_a.class_err, 1'b0);

        // Fairness burst; pushes trail pops by two cycles.
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fair_pop", bus_a.pop, 4'b1 << exp_idx(k));
            if (k >= 2) begin
                chk("fair_push", bus_a.push, 4'b1 << exp_idx(k - 2));
                chk("fair_data", bus_a.data_out, word(exp_idx(k - 2)));
            end
            tick();
        end

        // Backpressure mid-burst: only the two in-flight words complete.
        bus_a.out_almost_full = 4'b0010;
        #1;
        chk("bp_pop0", bus_a.pop, 4'b0000);
        chk("bp_push0", bus_a.push, 4'b1 << exp_idx(3));
        tick();
        chk("bp_pop1", bus_a.pop, 4'b0000);
        chk("bp_push1", bus_a.push, 4'b1 << exp_idx(4));
        chk("bp_data1", bus_a.data_out, word(exp_idx(4)));
        tick();
        chk("bp_pop2", bus_a.pop, 4'b0000);
        chk("bp_push2", bus_a.push, 4'b0000);
        tick();
        bus_a.out_almost_full = 4'b0000;
        #1;
        chk("bp_resume", bus_a.pop, 4'b1 << exp_idx(5));
        tick();
        bus_a.in_empty = 4'b1111;
        #1;
        chk("drain_pop", bus_a.pop, 4'b0000);
        chk("drain_push", bus_a.push, 4'b0000);
        tick();
        chk("resume_push", bus_a.push, 4'b1 << exp_idx(5));
        tick();
        chk("drain_idle", bus_a.idle, 1'b1);

        // Routing: only input 2 holds class-2 word 0x205.
        bus_a.in_data[2*10 +: 10] = 10'b10_00000101;
        bus_a.in_empty = 4'b1011;
        #1;
        chk("route_pop", bus_a.pop, 4'b0100);
        tick();
        bus_a.in_empty = 4'b1111;
        #1;
        chk("route_pop1", bus_a.pop, 4'b0000);
        chk("route_busy", bus_a.idle, 1'b0);
        tick();
        chk("route_push", bus_a.push, 4'b0100);
        chk("route_data", bus_a.data_out, 10'h205);
        chk("route_cerr", bus_a.class_err, 1'b0);
        tick();
        chk("route_done", bus_a.push, 4'b0000);
        chk("route_idle", bus_a.idle, 1'b1);

        // A lone non-empty input wins every cycle, then the scan wraps to 0.
        bus_a.in_empty = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("single_pop", bus_a.pop, 4'b1000);
            tick();
        end
        bus_a.in_empty = 4'b0110;
        #1;
        chk("wrap_pop", bus_a.pop, 4'b0001);
        tick();

        // Almost-full arrives together with requests: no pop, in-flight finishes.
        bus_a.in_empty = 4'b0000;
        bus_a.out_almost_full = 4'b1000;
        #1;
        chk("af_same_pop", bus_a.pop, 4'b0000);
        chk("af_same_push3", bus_a.push, 4'b1000);
        tick();
        chk("af_hold_pop", bus_a.pop, 4'b0000);
        chk("af_inflight", bus_a.push, 4'b0001);
        chk("af_inflight_d", bus_a.data_out, word(0));
        tick();
        chk("af_quiet", bus_a.push, 4'b0000);
        bus_a.out_almost_full = 4'b0000;
        bus_a.in_empty = 4'b1111;

        // Reset the cycle after a pop: the word is discarded.
        bus_a.in_empty = 4'b1101;
        #1;
        chk("mid_pop", bus_a.pop, 4'b0010);
        tick();
        reset = 1'b1;
        bus_a.in_empty = 4'b1111;
        #1;
        chk("mid_rst_pop", bus_a.pop, 4'b0000);
        tick();
        chk("mid_push0", bus_a.push, 4'b0000);
        chk("mid_idle", bus_a.idle, 1'b1);
        reset = 1'b0;
        tick();
        chk("mid_push1", bus_a.push, 4'b0000);

        // Three-class instance: class 2'b11 is dropped and flagged.
        bus_b.in_data[0*10 +: 10] = 10'h35A;
        bus_b.in_data[1*10 +: 10] = 10'h2A5;
        bus_b.in_empty = 4'b1110;
        #1;
        chk("cerr_pop", bus_b.pop, 4'b0001);
        tick();
        bus_b.in_empty = 4'b1111;
        tick();
        chk("cerr_push", bus_b.push, 3'b000);
        chk("cerr_flag", bus_b.class_err, 1'b1);
        bus_b.in_empty = 4'b1101;
        #1;
        chk("cerr_next_pop", bus_b.pop, 4'b0010);
        tick();
        bus_b.in_empty = 4'b1111;
        chk("cerr_pulse", bus_b.class_err, 1'b0);
        tick();
        chk("cls2_push", bus_b.push, 3'b100);
        chk("cls2_data", bus_b.data_out, 10'h2A5);
        chk("cls2_cerr", bus_b.class_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_class_arbiter.md
# pcie_class_arbiter

Parametrised class-routing arbiter in the PCIE datapath, between NUM_IN input FIFOs and NUM_OUT per-class output FIFOs.

- Selects one non-empty input per cycle, pops it, reads the class field of the returned word, and pushes the word into the matching output FIFO.
- Generalises the single-input, four-class arbiter to multiple inputs, with round-robin fairness and a registered output pipeline.
- Flags words whose class has no output FIFO.

## Interface
- NUM_IN, 4, number of input FIFOs (≥1).
- NUM_OUT, 4, number of output FIFOs / classes (≥2).
- DATA_W, 10, word width; class field is data[DATA_W-1 -: CLASS_W].
- CLASS_W is a localparam, $clog2(NUM_OUT).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_empty  in  NUM_IN  per-input FIFO empty flag.
- in_data  in  NUM_IN*DATA_W  flattened input FIFO read data; input i at [i*DATA_W +: DATA_W].
- out_almost_full  in  NUM_OUT  per-output FIFO almost-full flag.
- pop  out  NUM_IN  one-hot read strobe to input FIFOs (combinational).
- push  out  NUM_OUT  one-hot write strobe to output FIFOs (registered).
- data_out  out  DATA_W  word written with push (registered).
- class_err  out  1  one-cycle pulse: word dropped for out-of-range class (registered).
- idle  out  1  high when no word is in flight in stages S1/S2.

## Operation
- Grant condition in cycle N: reset low, no bit of out_almost_full set, and at least one in_empty bit low.
- Backpressure is global: any almost-full output stalls all pops.
- Grant choice:
  - Round-robin scan starts at input (last_grant+1) mod NUM_IN.
  - The first non-empty input is granted, and pop[g] is high for cycle N only.
  - last_grant updates to g on each grant and holds otherwise.
- Stage S1 (cycle N+1):
  - s1_valid and s1_sel hold the grant.
  - The input FIFO presents the popped word on in_data during N+1.
- Stage S2 (edge ending N+1): if s1_valid, capture in_data[s1_sel] into data_out and decode the class field cls.
  - cls < NUM_OUT: push = one-hot(cls) during N+2.
  - cls ≥ NUM_OUT: push = 0 and class_err = 1 during N+2; the word is dropped.
- push and class_err are 0 in every cycle without a valid S2 word.
- Back-to-back grants are allowed, giving one pop per cycle and one push per cycle in steady state.
- idle = !s1_valid && !s2_valid.
- Output FIFOs must assert almost_full with ≥2 free entries remaining. Up to 2 words may be in flight when almost_full rises, and the arbiter never drops in-flight words for backpressure.
- in_empty is sampled only in the grant cycle. An empty flag rising in N+1 does not affect the popped word.

## Timing
- Reset values: pop=0, push=0, data_out=0, class_err=0, idle=1, s1_valid=s2_valid=0, last_grant=NUM_IN-1 (input 0 wins first).
- pop is held 0 during any cycle with reset high.
- Latency: pop in N → push/data_out valid in N+2.
- Reset mid-operation: in-flight S1/S2 words are discarded without push. The word already popped is lost, which is accepted behaviour.
- Simultaneous almost_full rise and grant request in the same cycle: no pop. In-flight words still complete.
- Single non-empty input: granted every eligible cycle regardless of last_grant.
- Wrap-around: last_grant=NUM_IN-1 scans from input 0.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin grant as described, with the last_grant register present.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest-index non-empty input always wins, and last_grant is not implemented.
- All other behaviour and the latency are identical in both builds.

## Test plan
- Reset: hold reset 3 cycles with all inputs non-empty → pop=0, push=0, idle=1. First grant after release is pop=4'b0001.
- Routing (NUM_IN=4, NUM_OUT=4, DATA_W=10): input 2 holds word 10'b10_00000101, the rest empty → pop=4'b0100 in N, push=4'b0100 and data_out=0x205 in N+2.
- Fairness (RR build): all four inputs non-empty continuously → pop sequence 0001, 0010, 0100, 1000, 0001. Fixed-priority build: pop=0001 every cycle.
- Backpressure: out_almost_full=4'b0010 rises during a burst → pop=0 from that cycle. Exactly the ≤2 in-flight words are pushed. Pops resume the cycle after almost_full clears.
- Class error (NUM_OUT=3): word with class 2'b11 → push=0 and class_err=1 for one cycle at N+2. Next valid word routes normally.
- Reset mid-flight: assert reset the cycle after a pop → no push in the following two cycles, and idle=1 after the reset edge.
